alu_unit: RTL and testbench

- 8-bit ALU stage directly downstream of the two-register set.
- Operand A comes from the register set's ALU output. Operand B is latched from the data bus into an internal B register.
- Registers the result and the Z/C/N/V flags, and drives the result onto the shared bus through a transmitter.
- Single-cycle ops take one clock edge; the multiply is a multi-cycle shift-add with a busy/done handshake to the control sequencer.

---
 rtl/alu_unit_if.sv | 23 ++
 rtl/alu_unit.sv | 166 ++++++++++++++++
 tb/tb_alu_unit.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_unit_if.sv
// Operand, control and result signals between the control sequencer and the ALU stage.
interface alu_unit_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_bus;
  logic             i_loadB;
  logic [3:0]       i_op;
  logic             i_start;
  logic             i_busEn;
  logic [WIDTH-1:0] o_result;
  logic [3:0]       o_flags;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_a, i_bus, i_loadB, i_op, i_start, i_busEn,
    output o_result, o_flags, o_busy, o_done
  );

  modport master (
    output i_a, i_bus, i_loadB, i_op, i_start, i_busEn,
    input  o_result, o_flags, o_busy, o_done
  );
endinterface

// File: rtl/alu_unit.sv
// ALU stage: B register, single-cycle arithmetic/logic/shift ops, shift-add multiply,
// result/flag registers and a tristate bus transmitter.
module alu_unit #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  alu_unit_if.slave        alu_if,
  output logic [WIDTH-1:0] o_bus
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;
  localparam logic [3:0] OP_ASR = 4'd10;
  localparam logic [3:0] OP_ROL = 4'd11;
  localparam logic [3:0] OP_INC = 4'd14;
  localparam logic [3:0] OP_DEC = 4'd15;

  logic [0:0]         state;
  logic [WIDTH-1:0]   b_reg;
  logic [WIDTH-1:0]   result;
  logic [3:0]         flags;
  logic               done;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic               mul_hi;

  logic [WIDTH+3:0]   alu_out;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   mul_res;
  logic [3:0]         mul_flags;

  // Returns {result, Z, C, N, V}. Subtract forms add the inverted operand so C means "no borrow".
  function automatic logic [WIDTH+3:0] alu_op(
    input logic [3:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             cin
  );
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] bx;
    logic [WIDTH:0]   sum;
    logic             c;
    logic             v;
    logic             ci;
    logic             arith;
    r     = '0;
    bx    = '0;
    sum   = '0;
    c     = 1'b0;
    v     = 1'b0;
    ci    = 1'b0;
    arith = 1'b0;
    case (op)
      OP_ADD: begin bx = b;                ci = 1'b0; arith = 1'b1; end
      OP_ADC: begin bx = b;                ci = cin;  arith = 1'b1; end
      OP_SUB: begin bx = ~b;               ci = 1'b1; arith = 1'b1; end
      OP_SBC: begin bx = ~b;               ci = cin;  arith = 1'b1; end
      OP_INC: begin bx = WIDTH'(1);        ci = 1'b0; arith = 1'b1; end
      OP_DEC: begin bx = ~(WIDTH'(1));     ci = 1'b1; arith = 1'b1; end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin r = {a[WIDTH-2:0], 1'b0};     c = a[WIDTH-1]; end
      OP_SHR: begin r = {1'b0, a[WIDTH-1:1]};     c = a[0];       end
      OP_ASR: begin r = {a[WIDTH-1], a[WIDTH-1:1]}; c = a[0];     end
      OP_ROL: begin r = {a[WIDTH-2:0], cin};      c = a[WIDTH-1]; end
      default: ;
    endcase
    if (arith) begin
      sum = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, ci};
      r   = sum[WIDTH-1:0];
      c   = sum[WIDTH];
      v   = (a[WIDTH-1] == bx[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
    end
    return {r, (r == '0), c, r[WIDTH-1], v};
  endfunction

  always_comb begin
    alu_out   = alu_op(alu_if.i_op, alu_if.i_a, b_reg, flags[2]);
    acc_next  = acc;
    if (mplier[0]) begin
      acc_next = acc + ({{WIDTH{1'b0}}, mcand} << cnt);
    end
    mul_res   = mul_hi ? acc_next[2*WIDTH-1:WIDTH] : acc_next[WIDTH-1:0];
    mul_flags = {(mul_res == '0),
                 mul_hi ? 1'b0 : (acc_next[2*WIDTH-1:WIDTH] != '0),
                 mul_res[WIDTH-1],
                 1'b0};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= IDLE;
      b_reg  <= '0;
      result <= '0;
      flags  <= '0;
      done   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      mul_hi <= 1'b0;
    end else begin
      done <= 1'b0;
      if (alu_if.i_loadB) begin
        b_reg <= alu_if.i_bus;
      end
      case (state)
        IDLE: begin
          if (alu_if.i_start) begin
            if (alu_if.i_op[3:1] == 3'b110) begin
              state  <= MUL;
              mcand  <= alu_if.i_a;
              mplier <= b_reg;
              acc    <= '0;
              cnt    <= '0;
              mul_hi <= alu_if.i_op[0];
            end else begin
              result <= alu_out[WIDTH+3:4];
              flags  <= alu_out[3:0];
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          // One shift-add iteration per edge; the last one writes the product byte.
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            state  <= IDLE;
            result <= mul_res;
            flags  <= mul_flags;
            done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_if.o_result = result;
  assign alu_if.o_flags  = flags;
  assign alu_if.o_busy   = (state == MUL);
  assign alu_if.o_done   = done;
  assign o_bus           = alu_if.i_busEn ? result : 'z;

endmodule

// File: tb/tb_alu_unit.sv
// Randomized and directed checks of alu_unit against an arithmetic reference model.
module tb_alu_unit;

  logic       clk = 1'b0;
  logic       rst;
  wire  [7:0] bus_out;

  alu_unit_if #(.WIDTH(8)) dut_if ();

  alu_unit #(.WIDTH(8)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .alu_if  (dut_if.slave),
    .o_bus   (bus_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] b_m;
  logic [7:0] res_m;
  logic [3:0] flags_m;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: {result, Z, C, N, V} from integer arithmetic on the operand values.
  function automatic logic [11:0] model(input logic [3:0] op, input logic [7:0] a,
                                        input logic [7:0] b, input logic cin);
    int ua, ub, sa, sb, s, ss, p, ci;
    logic [31:0] r;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    ci = cin ? 1 : 0;
    s = 0; ss = 0; p = ua * ub;
    r = 0; c = 1'b0; v = 1'b0;
    case (op)
      4'd0:  begin s = ua + ub;          ss = sa + sb;          c = (s > 255); end
      4'd1:  begin s = ua + ub + ci;     ss = sa + sb + ci;     c = (s > 255); end
      4'd2:  begin s = ua - ub;          ss = sa - sb;          c = (s >= 0);  end
      4'd3:  begin s = ua - ub - (1-ci); ss = sa - sb - (1-ci); c = (s >= 0);  end
      4'd14: begin s = ua + 1;           ss = sa + 1;           c = (s > 255); end
      4'd15: begin s = ua - 1;           ss = sa - 1;           c = (s >= 0);  end
      4'd4:  s = ua & ub;
      4'd5:  s = ua | ub;
      4'd6:  s = ua ^ ub;
      4'd7:  s = 255 - ua;
      4'd8:  begin s = ua * 2;      c = (ua >= 128); end
      4'd9:  begin s = ua / 2;      c = (ua % 2 == 1); end
      4'd10: begin s = sa >>> 1;    c = (ua % 2 == 1); end
      4'd11: begin s = ua * 2 + ci; c = (ua >= 128); end
      4'd12: begin s = p % 256;     c = (p >= 256); end
      default: s = p / 256;
    endcase
    if (op <= 4'd3 || op >= 4'd14) v = (ss > 127) || (ss < -128);
    r = 32'(s);
    return {r[7:0], (r[7:0] == 8'h00), c, r[7], v};
  endfunction

  task automatic load_b(input logic [7:0] val);
    dut_if.i_bus   = val;
    dut_if.i_loadB = 1'b1;
    tick();
    dut_if.i_loadB = 1'b0;
    b_m = val;
  endtask

  task automatic check_bus();
    bit hiz;
    if (dut_if.i_busEn) begin
      check("bus_on", 16'(bus_out), 16'(res_m));
    end else begin
      hiz = (bus_out === 8'bz) || (bus_out === 8'h00);
      check("bus_hiz", 16'(hiz), 16'd1);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [7:0] a,
                        input bit disturb, input logic [7:0] nb);
    logic [11:0] exp;
    exp = model(op, a, b_m, flags_m[2]);
    dut_if.i_a     = a;
    dut_if.i_op    = op;
    dut_if.i_start = 1'b1;
    tick();
    dut_if.i_start = 1'b0;
    if (op == 4'd12 || op == 4'd13) begin
      for (int i = 0; i < 8; i++) begin
        check("mul_busy", 16'(dut_if.o_busy), 16'd1);
        check("mul_nodone", 16'(dut_if.o_done), 16'd0);
        check("mul_hold", 16'(dut_if.o_result), 16'(res_m));
        if (disturb && i == 2) begin
          dut_if.i_start = 1'b1;
          dut_if.i_op    = 4'd0;
          dut_if.i_a     = ~a;
          dut_if.i_bus   = nb;
          dut_if.i_loadB = 1'b1;
        end
        tick();
        if (disturb && i == 2) begin
          dut_if.i_start = 1'b0;
          dut_if.i_loadB = 1'b0;
          b_m = nb;
        end
      end
    end
    check("done", 16'(dut_if.o_done), 16'd1);
    check("busy_end", 16'(dut_if.o_busy), 16'd0);
    check("result", 16'(dut_if.o_result), 16'(exp[11:4]));
    check("flags", 16'(dut_if.o_flags), 16'(exp[3:0]));
    res_m   = exp[11:4];
    flags_m = exp[3:0];
    check_bus();
    tick();
    check("done_clr", 16'(dut_if.o_done), 16'd0);
  endtask

  initial begin
    logic [7:0] ra;
    logic [7:0] rb;
    dut_if.i_a     = '0;
    dut_if.i_bus   = '0;
    dut_if.i_loadB = 1'b0;
    dut_if.i_op    = '0;
    dut_if.i_start = 1'b0;
    dut_if.i_busEn = 1'b1;
    b_m = '0; res_m = '0; flags_m = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_result", 16'(dut_if.o_result), 16'h0);
    check("rst_flags", 16'(dut_if.o_flags), 16'h0);
    check("rst_busy", 16'(dut_if.o_busy), 16'h0);
    check("rst_done", 16'(dut_if.o_done), 16'h0);

    load_b(8'h01);
    run_op(4'd0, 8'h7F, 1'b0, 8'h00);
    check("add_res", 16'(dut_if.o_result), 16'h80);
    check("add_flags", 16'(dut_if.o_flags), 16'b0011);

    load_b(8'h10);
    run_op(4'd2, 8'h10, 1'b0, 8'h00);
    check("sub_res", 16'(dut_if.o_result), 16'h00);
    check("sub_flags", 16'(dut_if.o_flags), 16'b1100);
    load_b(8'h01);
    run_op(4'd3, 8'h00, 1'b0, 8'h00);
    check("sbc_res", 16'(dut_if.o_result), 16'hFF);
    check("sbc_flags", 16'(dut_if.o_flags), 16'b0010);

    load_b(8'h34);
    run_op(4'd12, 8'h12, 1'b0, 8'h00);
    check("mull_res", 16'(dut_if.o_result), 16'hA8);
    check("mull_c", 16'(dut_if.o_flags[2]), 16'd1);
    run_op(4'd13, 8'h12, 1'b0, 8'h00);
    check("mulh_res", 16'(dut_if.o_result), 16'h03);
    check("mulh_c", 16'(dut_if.o_flags[2]), 16'd0);

    // Start/loadB/A changes during a multiply
    run_op(4'd12, 8'h12, 1'b1, 8'h02);
    check("dist_res", 16'(dut_if.o_result), 16'hA8);
    run_op(4'd0, 8'h01, 1'b0, 8'h00);
    check("newb_res", 16'(dut_if.o_result), 16'h03);

    // Reset in the middle of a multiply
    load_b(8'h34);
    dut_if.i_a = 8'h12; dut_if.i_op = 4'd12; dut_if.i_start = 1'b1;
    tick();
    dut_if.i_start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    b_m = '0; res_m = '0; flags_m = '0;
    check("abort_busy", 16'(dut_if.o_busy), 16'd0);
    check("abort_done", 16'(dut_if.o_done), 16'd0);
    check("abort_res", 16'(dut_if.o_result), 16'h00);
    check("abort_flags", 16'(dut_if.o_flags), 16'h0);
    tick();
    check("abort_idle", 16'({dut_if.o_busy, dut_if.o_done}), 16'd0);
    load_b(8'h05);
    run_op(4'd0, 8'h03, 1'b0, 8'h00);
    check("post_rst_add", 16'(dut_if.o_result), 16'h08);

    load_b(8'h00);
    run_op(4'd4, 8'hFF, 1'b0, 8'h00);
    run_op(4'd11, 8'h81, 1'b0, 8'h00);
    check("rol_res", 16'(dut_if.o_result), 16'h02);
    check("rol_c", 16'(dut_if.o_flags[2]), 16'd1);
    run_op(4'd10, 8'h81, 1'b0, 8'h00);
    check("asr_res", 16'(dut_if.o_result), 16'hC0);
    check("asr_flags", 16'(dut_if.o_flags), 16'b0110);

    dut_if.i_busEn = 1'b0;
    #1;
    check_bus();
    dut_if.i_busEn = 1'b1;
    #1;
    check_bus();

    // Back-to-back single-cycle starts
    dut_if.i_op = 4'd14; dut_if.i_a = 8'h41; dut_if.i_start = 1'b1;
    tick();
    check("b2b_done0", 16'(dut_if.o_done), 16'd1);
    check("b2b_res0", 16'(dut_if.o_result), 16'h42);
    dut_if.i_a = 8'h80;
    tick();
    dut_if.i_start = 1'b0;
    check("b2b_done1", 16'(dut_if.o_done), 16'd1);
    check("b2b_res1", 16'(dut_if.o_result), 16'h81);
    res_m = 8'h81; flags_m = 4'b0010;
    tick();
    check("b2b_clr", 16'(dut_if.o_done), 16'd0);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(2) == 0) begin
        rb = 8'($urandom);
        load_b(rb);
      end
      dut_if.i_busEn = 1'($urandom_range(1));
      ra = 8'($urandom);
      run_op(4'($urandom_range(15)), ra, 1'b0, 8'h00);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
